// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the pipeline MEM stage and a debug/DMA burst master.
// The CPU wins ties until the debug side has waited MAX_WAIT cycles, after which one burst preempts it.
module dmem_arbiter #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int MAX_WAIT   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_rd,
   input  logic                  cpu_wr,
   input  logic [DM_ADDRESS-1:0] cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   input  logic [2:0]            cpu_funct3,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  dbg_req,
   input  logic                  dbg_wr,
   input  logic [DM_ADDRESS-1:0] dbg_addr,
   input  logic [3:0]            dbg_len,
   input  logic [DATA_W-1:0]     dbg_wdata,
   output logic                  dbg_gnt,
   output logic [DATA_W-1:0]     dbg_rdata,
   output logic                  dbg_rvalid,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [2:0]            mem_funct3,
   input  logic [DATA_W-1:0]     mem_rdata
);
   typedef enum logic [1:0] {IDLE, CPU, DBG} state_t;
   state_t state, state_nx;
   logic [3:0] wait_cnt, beat_cnt, beat_idx;
   logic [DM_ADDRESS-1:0] base, beat_base;
   logic wr_flag, beat_wr, cpu_act, in_dbg, gnt, last;
   // First beat uses the live request fields; later beats use the values captured on that beat.
   always_comb begin
      cpu_act    = cpu_rd | cpu_wr;
      in_dbg     = state == DBG;
      gnt        = ~reset & dbg_req & (in_dbg | ~cpu_act | (wait_cnt == 4'(MAX_WAIT)));
      beat_idx   = in_dbg ? beat_cnt : 4'd0;
      beat_base  = in_dbg ? base : dbg_addr;
      beat_wr    = in_dbg ? wr_flag : dbg_wr;
      last       = beat_idx == dbg_len;
      state_nx   = gnt ? (last ? IDLE : DBG) : (cpu_act ? CPU : IDLE);
      dbg_gnt    = gnt;
      cpu_stall  = gnt & cpu_act;
      mem_rd     = ~reset & (gnt ? ~beat_wr : cpu_rd);
      mem_wr     = ~reset & (gnt ? beat_wr : cpu_wr);
      mem_addr   = gnt ? beat_base + DM_ADDRESS'({beat_idx, 2'b00}) : cpu_addr;
      mem_wdata  = gnt ? dbg_wdata : cpu_wdata;
      mem_funct3 = gnt ? 3'b010 : cpu_funct3;
      cpu_rdata  = mem_rdata;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         beat_cnt   <= '0;
         base       <= '0;
         wr_flag    <= 1'b0;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         state      <= state_nx;
         wait_cnt   <= (gnt | ~dbg_req) ? 4'd0 : (wait_cnt == 4'(MAX_WAIT)) ? wait_cnt : wait_cnt + 4'd1;
         dbg_rvalid <= gnt & ~beat_wr;
         if (gnt) beat_cnt <= beat_idx + 4'd1;
         if (gnt & ~in_dbg) begin
            base    <= dbg_addr;
            wr_flag <= dbg_wr;
         end
         if (gnt & ~beat_wr) dbg_rdata <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run against a burst-level reference model.
module tb_dmem_arbiter;
   logic clk = 0, reset = 1;
   logic cpu_rd = 0, cpu_wr = 0, dbg_req = 0, dbg_wr = 0;
   logic [8:0] cpu_addr = 0, dbg_addr = 0, mem_addr;
   logic [31:0] cpu_wdata = 0, dbg_wdata = 0, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
   logic [2:0] cpu_funct3 = 0, mem_funct3;
   logic [3:0] dbg_len = 0;
   logic cpu_stall, dbg_gnt, dbg_rvalid, mem_rd, mem_wr;
   int total = 0, bad = 0;

   dmem_arbiter dut (.clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_len(dbg_len), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_fn(input logic [8:0] a);
      return 32'h5A5A1234 ^ ({23'h0, a} * 32'h00010003);
   endfunction
   assign mem_rdata = rd_fn(mem_addr);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input int n);
      dbg_req = 0; cpu_rd = 0; cpu_wr = 0;
      repeat (n) tick();
   endtask

   task automatic test_reset;
      cpu_rd = 1; cpu_addr = 9'h055; dbg_req = 1;
      #3;
      total++;
      if ({dbg_gnt, cpu_stall, mem_rd, mem_wr, dbg_rvalid} !== 5'b0) begin
         bad++; $display("FAIL reset_outputs got=%b want=00000", {dbg_gnt, cpu_stall, mem_rd, mem_wr, dbg_rvalid});
      end
      total++;
      if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", dbg_rdata); end
      tick();
      reset = 0;
      quiet(2);
   endtask

   task automatic test_idle_burst;
      dbg_req = 1; dbg_wr = 0; dbg_addr = 9'h010; dbg_len = 2;
      for (int i = 0; i < 3; i++) begin
         #3;
         total++;
         if ({dbg_gnt, mem_rd, mem_wr, mem_addr, mem_funct3} !== {3'b110, 9'(9'h010 + 4 * i), 3'b010}) begin
            bad++; $display("FAIL idle_beat%0d got gnt=%b rd=%b wr=%b addr=%h f3=%b want addr=%h", i,
               dbg_gnt, mem_rd, mem_wr, mem_addr, mem_funct3, 9'(9'h010 + 4 * i));
         end
         total++;
         if (dbg_rvalid !== (i > 0)) begin bad++; $display("FAIL idle_rvalid%0d got=%b want=%b", i, dbg_rvalid, i > 0); end
         if (i > 0) begin
            total++;
            if (dbg_rdata !== rd_fn(9'(9'h010 + 4 * (i - 1)))) begin
               bad++; $display("FAIL idle_rdata%0d got=%h want=%h", i, dbg_rdata, rd_fn(9'(9'h010 + 4 * (i - 1))));
            end
         end
         tick();
      end
      dbg_req = 0;
      #3;
      total++;
      if ({dbg_gnt, dbg_rvalid, mem_rd} !== 3'b010 || dbg_rdata !== rd_fn(9'h018)) begin
         bad++; $display("FAIL idle_tail got gnt=%b rv=%b rd=%b rdata=%h want 010 %h", dbg_gnt, dbg_rvalid, mem_rd, dbg_rdata, rd_fn(9'h018));
      end
      tick();
      #3;
      total++;
      if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL idle_rvalid_end got=%b want=0", dbg_rvalid); end
      quiet(1);
   endtask

   task automatic test_contention;
      cpu_rd = 1; cpu_addr = 9'h0C4; dbg_req = 1; dbg_wr = 0; dbg_addr = 9'h040; dbg_len = 0;
      for (int c = 1; c <= 9; c++) begin
         #3;
         total++;
         if ({dbg_gnt, cpu_stall, mem_addr} !== {c == 9, c == 9, (c == 9) ? 9'h040 : 9'h0C4}) begin
            bad++; $display("FAIL contend_c%0d got gnt=%b stall=%b addr=%h", c, dbg_gnt, cpu_stall, mem_addr);
         end
         tick();
      end
      #3;
      total++;
      if ({dbg_gnt, cpu_stall, mem_addr} !== {2'b00, 9'h0C4}) begin
         bad++; $display("FAIL contend_after got gnt=%b stall=%b addr=%h want 0 0 0c4", dbg_gnt, cpu_stall, mem_addr);
      end
      quiet(2);
   endtask

   task automatic test_wrap;
      dbg_req = 1; dbg_wr = 1; dbg_addr = 9'h1FC; dbg_len = 1;
      for (int i = 0; i < 2; i++) begin
         dbg_wdata = $urandom;
         #3;
         total++;
         if ({dbg_gnt, mem_rd, mem_wr, mem_addr, mem_wdata} !== {3'b101, (i == 0) ? 9'h1FC : 9'h000, dbg_wdata}) begin
            bad++; $display("FAIL wrap_beat%0d got gnt=%b rd=%b wr=%b addr=%h wdata=%h", i, dbg_gnt, mem_rd, mem_wr, mem_addr, mem_wdata);
         end
         tick();
      end
      dbg_req = 0;
      #3;
      total++;
      if ({dbg_gnt, dbg_rvalid, mem_wr} !== 3'b000) begin
         bad++; $display("FAIL wrap_end got gnt=%b rv=%b wr=%b want 000", dbg_gnt, dbg_rvalid, mem_wr);
      end
      quiet(1);
   endtask

   task automatic test_abort;
      int beats = 0;
      dbg_req = 1; dbg_wr = 0; dbg_addr = 9'h080; dbg_len = 7;
      for (int i = 0; i < 3; i++) begin
         #3;
         beats += int'(dbg_gnt);
         total++;
         if (mem_addr !== 9'(9'h080 + 4 * i)) begin bad++; $display("FAIL abort_addr%0d got=%h want=%h", i, mem_addr, 9'(9'h080 + 4 * i)); end
         tick();
      end
      dbg_req = 0; cpu_rd = 1; cpu_addr = 9'h033;
      for (int i = 0; i < 4; i++) begin
         #3;
         beats += int'(dbg_gnt);
         total++;
         if ({cpu_stall, mem_rd, mem_addr} !== {2'b01, 9'h033}) begin
            bad++; $display("FAIL abort_cpu%0d got stall=%b rd=%b addr=%h want 0 1 033", i, cpu_stall, mem_rd, mem_addr);
         end
         tick();
      end
      total++;
      if (beats !== 3) begin bad++; $display("FAIL abort_beats got=%0d want=3", beats); end
      quiet(1);
   endtask

   task automatic test_reset_mid;
      dbg_req = 1; dbg_wr = 0; dbg_addr = 9'h100; dbg_len = 5;
      repeat (2) tick();
      #3;
      total++;
      if ({dbg_gnt, mem_addr} !== {1'b1, 9'h108}) begin bad++; $display("FAIL rstmid_beat2 got gnt=%b addr=%h want 1 108", dbg_gnt, mem_addr); end
      reset = 1;
      #1;
      total++;
      if ({dbg_gnt, mem_rd, mem_wr, dbg_rvalid} !== 4'b0) begin
         bad++; $display("FAIL rstmid_async got gnt=%b rd=%b wr=%b rv=%b want 0000", dbg_gnt, mem_rd, mem_wr, dbg_rvalid);
      end
      tick();
      reset = 0; dbg_req = 0; cpu_rd = 1; cpu_addr = 9'h0AB;
      #3;
      total++;
      if ({dbg_gnt, cpu_stall, mem_rd, dbg_rvalid, mem_addr} !== {4'b0010, 9'h0AB}) begin
         bad++; $display("FAIL rstmid_release got gnt=%b stall=%b rd=%b rv=%b addr=%h", dbg_gnt, cpu_stall, mem_rd, dbg_rvalid, mem_addr);
      end
      quiet(2);
   endtask

   // Reference: a burst is an ordered list of word addresses base+4k; the model tracks position in it.
   task automatic test_random;
      bit m_burst = 0, m_wr = 0, m_rv = 0, busy = 0, e_gnt, wr;
      int m_beat = 0, m_base = 0, m_wait = 0, idx, b;
      logic [31:0] m_rdata = 0;
      logic [8:0] e_addr;
      logic [47:0] got, want;
      reset = 1; tick(); reset = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(15) == 0) dbg_req = ~dbg_req;
         if ($urandom_range(31) == 0) busy = ~busy;
         if (!m_burst) begin
            dbg_wr = 1'($urandom); dbg_addr = 9'($urandom); dbg_len = 4'($urandom_range(0, 5));
         end
         b = (busy ? ($urandom_range(15) != 0) : ($urandom_range(3) == 0)) ? 1 + $urandom_range(1) : 0;
         cpu_rd = b == 1; cpu_wr = b == 2;
         cpu_addr = 9'($urandom); cpu_wdata = $urandom; cpu_funct3 = 3'($urandom); dbg_wdata = $urandom;
         #3;
         e_gnt = dbg_req && (m_burst || !(cpu_rd || cpu_wr) || m_wait == 8);
         idx = m_burst ? m_beat : 0;
         wr = m_burst ? m_wr : dbg_wr;
         e_addr = 9'(((m_burst ? m_base : int'(dbg_addr)) + 4 * idx) % 512);
         want = e_gnt ? {1'b1, cpu_rd | cpu_wr, !wr, wr, e_addr, dbg_wdata, 3'b010, m_rv}
                      : {2'b00, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_funct3, m_rv};
         got = {dbg_gnt, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3, dbg_rvalid};
         total++;
         if (got !== want) begin bad++; $display("FAIL rand_port n=%0d got=%h want=%h", n, got, want); end
         total++;
         if (dbg_rdata !== m_rdata || cpu_rdata !== mem_rdata) begin
            bad++; $display("FAIL rand_rdata n=%0d got=%h want=%h cpu_rdata=%h", n, dbg_rdata, m_rdata, cpu_rdata);
         end
         m_rv = e_gnt && !wr;
         if (m_rv) m_rdata = rd_fn(e_addr);
         if (e_gnt && idx != int'(dbg_len)) begin
            m_base = m_burst ? m_base : int'(dbg_addr); m_wr = wr; m_beat = idx + 1; m_burst = 1;
         end else m_burst = 0;
         m_wait = (e_gnt || !dbg_req) ? 0 : (m_wait < 8 ? m_wait + 1 : 8);
         tick();
      end
      quiet(1);
   endtask

   initial begin
      fork
         begin
            #2;
            test_reset();
            test_idle_burst();
            test_contention();
            test_wrap();
            test_abort();
            test_reset_mid();
            test_random();
         end
         begin
            #500000;
            bad++;
            $display("FAIL timeout");
         end
      join_any
      disable fork;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
